dll_sar_tracker: RTL

- Parametrised successive-approximation and tracking controller for the FMDLL delay-line code.
- Runs a WIDTH-bit binary search driven by the phase-detector comparator, then (optionally) switches to ±1 LSB tracking with dither-based lock detection.
- Single clock; replaces the fixed 10-bit SAR plus its divided update clock with an internal settle timer.
- Its `code` output drives the coarse/fine decoders directly.

---
 rtl/dll_ctrl_pkg.sv | 29 ++
 rtl/dll_settle_timer.sv | 34 +++
 rtl/dll_sar_tracker.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dll_ctrl_pkg.sv
// Shared types and constants for the FMDLL delay-line code controller.
package dll_ctrl_pkg;

  // Widest delay-line code any controller instance may drive.
  localparam int DLL_CODE_MAX_W = 16;

  // Controller states: search (S_*), tracking (T_*), idle and frozen hold.
  typedef enum logic [2:0] {
    IDLE,
    S_WAIT,
    S_DECIDE,
    T_WAIT,
    T_DECIDE,
    HOLD
  } dll_state_e;

  // Direction of the most recent tracking step, used for dither detection.
  typedef enum logic [1:0] {
    NONE,
    UP,
    DOWN
  } step_dir_e;

  // True while the binary search is in progress.
  function automatic logic is_search(input dll_state_e s);
    return (s == S_WAIT) || (s == S_DECIDE);
  endfunction

endpackage

// File: rtl/dll_settle_timer.sv
// Loadable down-counter that spaces a code change from the comparator sample.
// Loading sets the count to SETTLE; expire is high while the count equals 1,
// which is the last wait cycle before the decision cycle.
module dll_settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk_ext,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE);
  localparam logic [TW-1:0] ONE      = TW'(1);

  logic [TW-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expire = (count == ONE);

endmodule

// File: rtl/dll_sar_tracker.sv
// Successive-approximation search and +/-1 LSB tracking controller for the
// FMDLL delay-line code. A WIDTH-bit binary search driven by the phase
// detector is followed, when DLL_SAR_TRACK_EN is defined, by tracking with
// dither-based lock detection; otherwise the final code is held.
// Configuration macro: DLL_SAR_TRACK_EN.
module dll_sar_tracker
  import dll_ctrl_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SETTLE      = 4,
  parameter int LOCK_DITHER = 4
) (
  input  logic                     clk_ext,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     comp,
  output logic [WIDTH-1:0]         code,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     locked
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CODE_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CODE_ONE = WIDTH'(1);
  localparam logic [BIT_W-1:0] IDX_TOP  = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] IDX_ONE  = BIT_W'(1);

  dll_state_e       state, state_nxt;
  logic [WIDTH-1:0] code_nxt;
  logic [BIT_W-1:0] bit_idx_nxt;
  logic             done_nxt;
  logic             timer_load;
  logic             timer_expire;

`ifdef DLL_SAR_TRACK_EN
  step_dir_e        step_dir;
  logic             step_blocked;
`endif

  dll_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk_ext (clk_ext),
    .rst_n   (rst_n),
    .load    (timer_load),
    .expire  (timer_expire)
  );

  // Next-state, next-code and step decode; start overrides every state.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    code_nxt    = code;
    bit_idx_nxt = bit_idx;
    done_nxt    = 1'b0;
    timer_load  = 1'b0;
`ifdef DLL_SAR_TRACK_EN
    step_dir     = NONE;
    step_blocked = 1'b0;
`endif
    if (start) begin
      state_nxt   = S_WAIT;
      code_nxt    = CODE_MSB;
      bit_idx_nxt = IDX_TOP;
      timer_load  = 1'b1;
    end else begin
      case (state)
        IDLE, HOLD: begin
          // Wait for start; the code stays where it is.
        end
        S_WAIT: begin
          if (timer_expire) state_nxt = S_DECIDE;
        end
        S_DECIDE: begin
          if (!comp) code_nxt[bit_idx] = 1'b0;
          if (bit_idx != '0) begin
            code_nxt[bit_idx - IDX_ONE] = 1'b1;
            bit_idx_nxt = bit_idx - IDX_ONE;
            timer_load  = 1'b1;
            state_nxt   = S_WAIT;
          end else begin
            done_nxt = 1'b1;
`ifdef DLL_SAR_TRACK_EN
            timer_load = 1'b1;
            state_nxt  = T_WAIT;
`else
            state_nxt  = HOLD;
`endif
          end
        end
`ifdef DLL_SAR_TRACK_EN
        T_WAIT: begin
          if (timer_expire) state_nxt = T_DECIDE;
        end
        T_DECIDE: begin
          timer_load = 1'b1;
          state_nxt  = T_WAIT;
          if (comp) begin
            step_dir = UP;
            if (code == CODE_MAX) step_blocked = 1'b1;
            else                  code_nxt = code + CODE_ONE;
          end else begin
            step_dir = DOWN;
            if (code == '0) step_blocked = 1'b1;
            else            code_nxt = code - CODE_ONE;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, code and status registers; busy and done are registered outputs.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code    <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      code    <= code_nxt;
      bit_idx <= bit_idx_nxt;
      busy    <= is_search(state_nxt);
      done    <= done_nxt;
    end
  end

`ifdef DLL_SAR_TRACK_EN
  localparam int LOCK_W = $clog2(LOCK_DITHER + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_DITHER);
  localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

  logic [LOCK_W-1:0] rev_cnt;
  step_dir_e         last_dir;

  // Count consecutive direction reversals; lock once LOCK_DITHER are seen.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      rev_cnt  <= '0;
      locked   <= 1'b0;
      last_dir <= NONE;
    end else if (start) begin
      rev_cnt  <= '0;
      locked   <= 1'b0;
      last_dir <= NONE;
    end else if (state == T_DECIDE) begin
      if (step_blocked) begin
        rev_cnt  <= '0;
        locked   <= 1'b0;
        last_dir <= NONE;
      end else if ((last_dir != NONE) && (step_dir != last_dir)) begin
        if (rev_cnt != LOCK_MAX) rev_cnt <= rev_cnt + LOCK_ONE;
        if (rev_cnt >= LOCK_MAX - LOCK_ONE) locked <= 1'b1;
        last_dir <= step_dir;
      end else begin
        rev_cnt  <= '0;
        locked   <= 1'b0;
        last_dir <= step_dir;
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule
